// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one shared memory port.
// Round-robin on ties, fixed access latency, misaligned data trapped.
module mem_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [0:31] i_addr,
    output logic        i_ack,
    output logic [0:31] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic        d_half,
    input  logic        d_sext,
    input  logic [0:31] d_addr,
    input  logic [0:31] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [0:31] d_rdata,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wdata,
    output logic        mem_we,
    output logic        mem_byte,
    output logic        mem_half_word,
    output logic        mem_sign_extend,
    input  logic [0:31] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        grant_d;
    logic        last_grant;
    logic        pick_d;
    logic        misaligned;

    // Tie goes to the port not served last; a lone requester always wins.
    always_comb begin
        pick_d = d_req;
        if (i_req && d_req) begin
            pick_d = ~last_grant;
        end
    end

    // Half-words need an even address, words need a 4-byte boundary.
    always_comb begin
        misaligned = 1'b0;
        if (d_half) begin
            misaligned = d_addr[31];
        end else if (!d_byte) begin
            misaligned = |d_addr[30:31];
        end
    end

    // Memory port follows the granted requester only while accessing.
    always_comb begin
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_we          = 1'b0;
        mem_byte        = 1'b0;
        mem_half_word   = 1'b0;
        mem_sign_extend = 1'b0;
        if (state == ACCESS) begin
            if (grant_d) begin
                mem_addr        = d_addr;
                mem_wdata       = d_wdata;
                mem_we          = d_we && (cnt == 4'd0);
                mem_byte        = d_byte;
                mem_half_word   = d_half;
                mem_sign_extend = d_sext;
            end else begin
                mem_addr = i_addr;
            end
        end
    end

    // Arbitration FSM with registered acks and read-data holding registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant_d    <= 1'b0;
            last_grant <= 1'b1;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_d    <= pick_d;
                        last_grant <= pick_d;
                        if (pick_d && misaligned) begin
                            state   <= RESP;
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            state <= ACCESS;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        if (grant_d) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1; memory access cycles per transaction, legal range 1..15.
REQ-002 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low; state clears immediately while reset=0.
REQ-004 Port: i_req  in  1  instruction-fetch read request, held until i_ack.
REQ-005 Port: i_addr  in  [0:31]  fetch byte address.
REQ-006 Port: i_ack  out  1  one-cycle fetch completion pulse.
REQ-007 Port: i_rdata  out  [0:31]  fetch data, valid while i_ack=1.
REQ-008 Port: d_req  in  1  data request, held with all d_* qualifiers until d_ack.
REQ-009 Port: d_we, d_byte, d_half, d_sext  in  1 each  write, byte, half-word and sign-extend qualifiers.
REQ-010 Port: d_addr, d_wdata  in  [0:31]  data byte address and write data.
REQ-011 Port: d_ack  out  1  one-cycle data completion pulse.
REQ-012 Port: d_err  out  1  misaligned-access flag, valid only while d_ack=1.
REQ-013 Port: d_rdata  out  [0:31]  load data, valid while d_ack=1.
REQ-014 Port: mem_addr, mem_wdata  out  [0:31]  shared memory address and write data.
REQ-015 Port: mem_we, mem_byte, mem_half_word, mem_sign_extend  out  1 each  shared memory controls.
REQ-016 Port: mem_rdata  in  [0:31]  shared memory read data, combinational from mem_addr.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-018 IDLE SHALL sample i_req and d_req; if either is set, it SHALL register the grant, load cnt=LATENCY-1 and enter ACCESS at the next edge.
REQ-019 Simultaneous requests in IDLE SHALL be granted to the port not granted last (round-robin, last_grant bit).
REQ-020 A single requesting port SHALL be granted regardless of last_grant.
REQ-021 last_grant SHALL update on every grant.
REQ-022 In ACCESS, mem_addr and the mem_* qualifiers SHALL reflect the granted port's inputs.
- Fetch grant: mem_byte, mem_half_word and mem_sign_extend SHALL all be 0.
REQ-023 cnt SHALL decrement once per ACCESS cycle.
REQ-024 mem_we SHALL be 1 only in the ACCESS cycle with cnt=0 and only for a data write (exactly one write strobe).
REQ-025 In the ACCESS cycle with cnt=0, mem_rdata SHALL be captured into the granted port's rdata register and the FSM SHALL enter RESP.
REQ-026 RESP SHALL assert the granted port's ack for exactly one cycle, then return to IDLE.
REQ-027 Latency: request first seen in IDLE at cycle N -> ack at cycle N+LATENCY+1.
- Next IDLE sample at N+LATENCY+2, so back-to-back transactions are spaced LATENCY+2 cycles apart.
REQ-028 Misaligned data access SHALL be detected in IDLE at grant time:
- d_half=1 with d_addr[31]=1; or
- word access (d_byte=0, d_half=0) with d_addr[30:31]!=0.
REQ-029 A misaligned access SHALL skip ACCESS, go directly to RESP with d_ack=1, d_err=1 and d_rdata=0, and never assert mem_we.
REQ-030 Outside ACCESS, mem_addr, mem_wdata and all mem_* controls SHALL be 0.
REQ-031 i_rdata and d_rdata SHALL hold their last captured value between acks.
REQ-032 Requests dropped before ack are a protocol violation; the arbiter SHALL complete the granted transaction anyway, using the live inputs.
REQ-033 The idle port's ack SHALL remain 0 throughout another port's transaction.

Reset
REQ-034 With reset=0, outputs SHALL be: state=IDLE, cnt=0, last_grant=data (so fetch wins the first tie), all acks/d_err/mem_* =0, i_rdata=d_rdata=0.
REQ-035 Reset asserted mid-ACCESS SHALL abort the transaction with no ack; mem_we SHALL drop asynchronously.
REQ-036 The first grant SHALL be possible in the first IDLE cycle after reset returns to 1.

Verification
REQ-037 LATENCY=1, only i_req, i_addr=0x0000_0010, mem_rdata=0x8C42_2000 -> i_ack pulse at cycle N+2 with i_rdata=0x8C42_2000; mem_we=0 throughout.
REQ-038 i_req and d_req both from reset -> fetch granted first, then data.
- Ongoing requests then alternate I, D, I, D; acks spaced 3 cycles apart at LATENCY=1.
REQ-039 LATENCY=3, d_req write, d_addr=0x2000, d_wdata=0x0000_002A -> mem_we high for exactly one cycle (the third ACCESS cycle) with mem_addr=0x2000, then d_ack at N+4.
REQ-040 d_req half-word load at d_addr=0x2001 -> d_ack at N+1 with d_err=1, d_rdata=0; no ACCESS cycle and mem_addr stays 0.
REQ-041 reset driven 0 during the second ACCESS cycle (LATENCY=3) -> mem_we and acks 0 immediately; after release, a pending i_req wins over a simultaneous d_req.
